// File: rtl/morse_tone_if.sv
// Request/handshake bundle for morse_tone_seq: start strobe, tone parameters, busy/done status and beep lines.
// The mute line exists only when BEEP_MUTE_EN is defined.
interface morse_tone_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DUR_W  = 24
) ();
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              start;
    logic [CH_W-1:0]   ch_sel;
    logic [DIV_W-1:0]  half_period;
    logic [DUR_W-1:0]  duration;
    logic [DUR_W-1:0]  gap;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] beep;
`ifdef BEEP_MUTE_EN
    logic              mute;

    modport master (output start, ch_sel, half_period, duration, gap, mute,
                    input  busy, done, beep);
    modport slave  (input  start, ch_sel, half_period, duration, gap, mute,
                    output busy, done, beep);
`else
    modport master (output start, ch_sel, half_period, duration, gap,
                    input  busy, done, beep);
    modport slave  (input  start, ch_sel, half_period, duration, gap,
                    output busy, done, beep);
`endif
endinterface

// File: rtl/morse_tone_seq.sv
// Multi-channel square-wave tone sequencer: one request plays a tone of programmable half-period,
// length and trailing gap on one channel. Optional macro BEEP_MUTE_EN adds a registered output mute.
module morse_tone_seq #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DUR_W  = 24
) (
    input  logic         clk,
    input  logic         rst,
    morse_tone_if.slave  bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [NUM_CH-1:0] beep_q;
    logic [CH_W-1:0]   ch_q;
    logic [DIV_W-1:0]  hp_m1_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  gap_q;
    logic [DUR_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  hp_m1_d;

    // A zero half-period behaves like one, so the wrap point is never below zero.
    assign hp_m1_d = (bus.half_period == '0) ? '0 : bus.half_period - DIV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            beep_q    <= '0;
            ch_q      <= '0;
            hp_m1_q   <= '0;
            div_cnt_q <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        ch_q      <= bus.ch_sel;
                        hp_m1_q   <= hp_m1_d;
                        dur_q     <= bus.duration;
                        gap_q     <= bus.gap;
                        div_cnt_q <= '0;
                        cnt_q     <= '0;
                        if (bus.duration != '0) begin
                            state_q <= PLAY;
                            busy_q  <= 1'b1;
                        end else if (bus.gap != '0) begin
                            state_q <= GAP;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    cnt_q <= cnt_q + DUR_W'(1);
                    if (div_cnt_q == hp_m1_q) begin
                        div_cnt_q <= '0;
                        // Channels outside the implemented range never match, giving a silent tone.
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (32'(ch_q) == i) beep_q[i] <= ~beep_q[i];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                    // End of tone wins over a same-edge toggle.
                    if (cnt_q == dur_q - DUR_W'(1)) begin
                        beep_q <= '0;
                        cnt_q  <= '0;
                        if (gap_q != '0) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == gap_q - DUR_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DUR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    beep_q  <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef BEEP_MUTE_EN
    logic mute_q;

    // Mask only the outputs so the divider phase keeps running underneath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mute_q <= 1'b0;
        else     mute_q <= bus.mute;
    end

    assign bus.beep = beep_q & ~{NUM_CH{mute_q}};
`else
    assign bus.beep = beep_q;
`endif

endmodule
